// File: rtl/fp16_cvt_arbiter.sv
// fp16_cvt_arbiter: round-robin sharing of one uint12->fp16 converter among NUM_REQ requesters,
// with a registered tagged result on a valid/ready port and a wrapping conversion counter.
module uint12_to_fp16 (
  input  logic [11:0] a,
  output logic [15:0] y
);
  logic [3:0]  p;
  logic [11:0] norm;
  // Leading-one normalisation; bits below the 10-bit fraction are truncated.
  always_comb begin
    p = 4'd0;
    for (int i = 0; i < 12; i++) p = a[i] ? 4'(i) : p;
    norm = a << (4'd11 - p);
    y = a == 12'd0 ? 16'h0000 : {1'b0, 5'(p) + 5'd15, norm[10:1]};
  end
endmodule

module fp16_cvt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [12*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic [15:0]             cvt_count
);
  localparam int SW = TAG_W + 1;
  logic [TAG_W-1:0] rr_ptr, win, nxt;
  logic [SW-1:0]    idx;
  logic             any, xfer;
  logic [11:0]      operand;
  logic [15:0]      cvt_out;
  // Scan from lowest priority to highest so the requester nearest rr_ptr wins last.
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + SW'(k);
      idx = idx >= SW'(NUM_REQ) ? idx - SW'(NUM_REQ) : idx;
      if (req_valid[idx[TAG_W-1:0]]) begin
        any = 1'b1;
        win = idx[TAG_W-1:0];
      end
    end
  end
  always_comb begin
    operand = 12'h000;
    for (int i = 0; i < NUM_REQ; i++) operand = any && win == TAG_W'(i) ? req_data[12*i +: 12] : operand;
  end
  assign xfer      = any && (!out_valid || out_ready) && !rst;
  assign req_ready = xfer ? NUM_REQ'(1) << win : '0;
  assign nxt       = win == TAG_W'(NUM_REQ - 1) ? '0 : win + 1'b1;
  uint12_to_fp16 u_cvt (.a(operand), .y(cvt_out));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_tag   <= '0;
      cvt_count <= 16'h0000;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= cvt_out;
      out_tag   <= win;
      cvt_count <= cvt_count + 16'd1;
      rr_ptr    <= nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp16_cvt_arbiter.sv
// tb_fp16_cvt_arbiter: scoreboard bench for the shared fp16 converter arbiter.
module tb_fp16_cvt_arbiter;
  localparam int N = 4;
  localparam int TW = 2;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [12*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [15:0]    out_data;
  logic [TW-1:0]  out_tag;
  logic [15:0]    cvt_count;
  int checks = 0;
  int errors = 0;
  logic          m_ov = 1'b0;
  int            m_ptr = 0;
  logic [15:0]   m_cnt = 16'h0000;
  logic [TW+15:0] sb[$];

  fp16_cvt_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .cvt_count(cvt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_fp16(input logic [11:0] a);
    int e;
    int v;
    if (a == 12'd0) return 16'h0000;
    e = 0;
    v = int'(a);
    while (v > 1) begin
      v = v >> 1;
      e++;
    end
    return {1'b0, 5'(e + 15), 10'(((int'(a) << 10) >> e) & 'h3FF)};
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] er;
    logic [1:0] ix;
    int g;
    if (rst) begin
      checks++;
      if (out_valid !== 1'b0 || req_ready !== '0 || cvt_count !== 16'h0 || out_data !== 16'h0 || out_tag !== '0) begin
        errors++;
        $display("FAIL reset_state: valid=%b ready=%b count=%h data=%h tag=%0d, need all zero", out_valid, req_ready, cvt_count, out_data, out_tag);
      end
      m_ov = 1'b0;
      m_ptr = 0;
      m_cnt = 16'h0000;
      sb.delete();
    end else begin
      checks++;
      if (out_valid !== m_ov) begin
        errors++;
        $display("FAIL sb_out_valid: got %b expected %b", out_valid, m_ov);
      end
      checks++;
      if (cvt_count !== m_cnt) begin
        errors++;
        $display("FAIL sb_cvt_count: got %h expected %h", cvt_count, m_cnt);
      end
      if (m_ov) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got result with empty scoreboard, expected none");
        end else if ({out_tag, out_data} !== sb[0]) begin
          errors++;
          $display("FAIL sb_result: got tag=%0d data=%h expected tag=%0d data=%h", out_tag, out_data, sb[0][TW+15:16], sb[0][15:0]);
        end
      end
      g = -1;
      for (int k = N - 1; k >= 0; k--) begin
        ix = 2'((m_ptr + k) % N);
        if (req_valid[ix]) g = int'(ix);
      end
      er = (g >= 0 && (!m_ov || out_ready)) ? 4'(1) << g : '0;
      checks++;
      if (req_ready !== er) begin
        errors++;
        $display("FAIL sb_req_ready: got %b expected %b", req_ready, er);
      end
      if (m_ov && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (er != '0) begin
        sb.push_back({TW'(g), ref_fp16(req_data[12*g +: 12])});
        m_ov = 1'b1;
        m_ptr = (g + 1) % N;
        m_cnt = m_cnt + 16'd1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || out_valid !== 1'b0 || cvt_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b valid=%b count=%h, need 0000/0/0000", req_ready, out_valid, cvt_count);
    end
    step();
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    req_data[11:0] = 12'd1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b expected 0001", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h3C00 || out_tag !== 2'd0 || cvt_count !== 16'd1) begin
      errors++;
      $display("FAIL single_result: got v=%b d=%h t=%0d c=%0d expected 1/3c00/0/1", out_valid, out_data, out_tag, cvt_count);
    end
    step();
  endtask

  task automatic test_values();
    logic [11:0] v [4] = '{12'd3, 12'd1024, 12'hFFF, 12'd0};
    logic [15:0] e [4] = '{16'h4200, 16'h6400, 16'h6BFF, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        req_valid = 4'b0100;
        req_data[35:24] = v[i];
      end else begin
        req_valid = '0;
      end
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== e[i-1] || out_tag !== 2'd2) begin
          errors++;
          $display("FAIL value_%0d: got v=%b d=%h t=%0d expected 1/%h/2", i - 1, out_valid, out_data, out_tag, e[i-1]);
        end
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_data = {12'd2047, 12'd300, 12'd17, 12'd5};
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(4'b0001 << (k % 4))) begin
        errors++;
        $display("FAIL rr_ready_%0d: got %b expected %b", k, req_ready, 4'(4'b0001 << (k % 4)));
      end
      if (k > 0) begin
        checks++;
        if (out_tag !== 2'((k - 1) % 4)) begin
          errors++;
          $display("FAIL rr_tag_%0d: got %0d expected %0d", k, out_tag, (k - 1) % 4);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || out_tag !== 2'd1 || out_data !== ref_fp16(12'd17) || cvt_count !== 16'd6) begin
        errors++;
        $display("FAIL bp_hold_%0d: got r=%b t=%0d d=%h c=%0d expected 0000/1/%h/6", j, req_ready, out_tag, out_data, cvt_count, ref_fp16(12'd17));
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 0100", req_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 2'd2 || out_data !== ref_fp16(12'd300) || cvt_count !== 16'd7) begin
      errors++;
      $display("FAIL bp_release_result: got v=%b t=%0d d=%h c=%0d expected 1/2/%h/7", out_valid, out_tag, out_data, cvt_count, ref_fp16(12'd300));
    end
    step();
  endtask

  task automatic test_pointer();
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL ptr_grant3: got %b expected 1000", req_ready);
    end
    step();
    req_valid = '0;
    repeat (5) step();
    req_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL ptr_first: got %b expected 0010", req_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000 || out_tag !== 2'd1) begin
      errors++;
      $display("FAIL ptr_second: got r=%b t=%0d expected 1000/1", req_ready, out_tag);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_tag !== 2'd3) begin
      errors++;
      $display("FAIL ptr_tag3: got %0d expected 3", out_tag);
    end
    step();
  endtask

  task automatic test_wrap_reset();
    int n = 0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    while (m_cnt != 16'hFFFF && n < 70000) begin
      step();
      n++;
    end
    req_valid = '0;
    if (n >= 70000) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout: count %h never reached ffff", cvt_count);
    end
    @(negedge clk);
    checks++;
    if (cvt_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h expected ffff", cvt_count);
    end
    step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (cvt_count !== 16'h0000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_count: got c=%h v=%b expected 0000/1", cvt_count, out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || cvt_count !== 16'h0000 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: got v=%b c=%h d=%h expected 0/0000/0000", out_valid, cvt_count, out_data);
    end
    step();
    @(negedge clk);
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_priority: got %b expected 0001", req_ready);
    end
    step();
    req_valid = '0;
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_values();
    test_round_robin();
    test_backpressure();
    test_pointer();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
